// File: rtl/elvm_pkg.sv
// elvm_pkg: shared definitions for the parametrised ELVM core.
//  - opcode encodings (5-bit op field)
//  - instruction field offsets, expressed relative to DW because the
//    immediate occupies the low DW bits of every instruction word
//  - register index constants
//  - FSM state encoding
package elvm_pkg;

  // Opcodes
  localparam logic [4:0] OP_MOV   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_LOAD  = 5'd3;
  localparam logic [4:0] OP_STORE = 5'd4;
  localparam logic [4:0] OP_PUTC  = 5'd5;
  localparam logic [4:0] OP_GETC  = 5'd6;
  localparam logic [4:0] OP_EXIT  = 5'd7;
  localparam logic [4:0] OP_EQ    = 5'd8;
  localparam logic [4:0] OP_NE    = 5'd9;
  localparam logic [4:0] OP_LT    = 5'd10;
  localparam logic [4:0] OP_GT    = 5'd11;
  localparam logic [4:0] OP_LE    = 5'd12;
  localparam logic [4:0] OP_GE    = 5'd13;
  localparam logic [4:0] OP_JEQ   = 5'd14;
  localparam logic [4:0] OP_JNE   = 5'd15;
  localparam logic [4:0] OP_JLT   = 5'd16;
  localparam logic [4:0] OP_JGT   = 5'd17;
  localparam logic [4:0] OP_JLE   = 5'd18;
  localparam logic [4:0] OP_JGE   = 5'd19;
  localparam logic [4:0] OP_JMP   = 5'd20;

  // Instruction layout: {op[4:0], src_imm, dst[2:0], src[2:0], imm[DW-1:0]}
  // Field LSB position = DW + offset below.
  localparam int F_SRC_OFS  = 0;
  localparam int F_DST_OFS  = 3;
  localparam int F_SIMM_OFS = 6;
  localparam int F_OP_OFS   = 7;

  // Register indices; 6 and 7 read as zero and ignore writes.
  localparam logic [2:0] REG_A  = 3'd0;
  localparam logic [2:0] REG_B  = 3'd1;
  localparam logic [2:0] REG_C  = 3'd2;
  localparam logic [2:0] REG_D  = 3'd3;
  localparam logic [2:0] REG_SP = 3'd4;
  localparam logic [2:0] REG_BP = 3'd5;
  localparam int NUM_REGS = 6;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_PUTC  = 3'd2,
    ST_GETC  = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

endpackage

// File: rtl/elvm_regfile.sv
// elvm_regfile: ELVM register file, 8 architectural indices, 6 real registers.
//  clk, rst_n : clock, asynchronous active-low reset (all registers -> 0)
//  ra_a/rd_a  : async read port A (index, data)
//  ra_b/rd_b  : async read port B (index, data)
//  we/wa/wd   : write enable, index, data (indices 6,7 silently dropped)
module elvm_regfile
  import elvm_pkg::*;
#(
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    ra_a,
  output logic [DW-1:0] rd_a,
  input  logic [2:0]    ra_b,
  output logic [DW-1:0] rd_b,
  input  logic          we,
  input  logic [2:0]    wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wa == 3'(i)) regs_q[i] <= wd;
      end
    end
  end

  assign rd_a = (ra_a < 3'(NUM_REGS)) ? regs_q[ra_a] : '0;
  assign rd_b = (ra_b < 3'(NUM_REGS)) ? regs_q[ra_b] : '0;

endmodule

// File: rtl/elvm_core_param.sv
// elvm_core_param: multi-cycle ELVM execution core.
//  clk, rst_n          : clock, asynchronous active-low reset
//  imem_addr/imem_rdata: external ROM, rdata valid the cycle after addr
//  putc_*              : output byte stream (valid/ready)
//  getc_*              : input byte stream (ready/valid, eof qualifies valid)
//  halted              : EXIT or undefined opcode executed, frozen until reset
//  pc                  : program counter (debug)
module elvm_core_param
  import elvm_pkg::*;
#(
  parameter  int DW     = 24,
  parameter  int PC_W   = 10,
  parameter  int MEM_AW = 8,
  localparam int IW     = DW + 12
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IW-1:0]   imem_rdata,
  output logic            putc_valid,
  output logic [7:0]      putc_data,
  input  logic            putc_ready,
  output logic            getc_ready,
  input  logic            getc_valid,
  input  logic [7:0]      getc_data,
  input  logic            getc_eof,
  output logic            halted,
  output logic [PC_W-1:0] pc
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            putc_valid_q, putc_valid_d;
  logic [7:0]      putc_data_q, putc_data_d;
  logic            getc_ready_q, getc_ready_d;
  logic            halted_q, halted_d;
  logic [2:0]      dst_q, dst_d;   // GETC target, held across the wait

  // Instruction fields
  logic [4:0]    f_op;
  logic          f_simm;
  logic [2:0]    f_dst, f_src;
  logic [DW-1:0] f_imm;
  assign f_op   = imem_rdata[DW+F_OP_OFS +: 5];
  assign f_simm = imem_rdata[DW+F_SIMM_OFS];
  assign f_dst  = imem_rdata[DW+F_DST_OFS +: 3];
  assign f_src  = imem_rdata[DW+F_SRC_OFS +: 3];
  assign f_imm  = imem_rdata[DW-1:0];

  logic [DW-1:0] d_val, src_reg, s_val, ram_rd;
  logic          rf_we;
  logic [2:0]    rf_wa;
  logic [DW-1:0] rf_wd;
  logic          ram_we;

  elvm_regfile #(.DW(DW)) u_rf (
    .clk  (clk),
    .rst_n(rst_n),
    .ra_a (f_dst),
    .rd_a (d_val),
    .ra_b (f_src),
    .rd_b (src_reg),
    .we   (rf_we),
    .wa   (rf_wa),
    .wd   (rf_wd)
  );

  assign s_val = f_simm ? f_imm : src_reg;

  // Data RAM: no reset, sync write, async read; address is truncated value.
  logic [DW-1:0] ram_q [2**MEM_AW];
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[s_val[MEM_AW-1:0]] <= d_val;
  end
  assign ram_rd = ram_q[s_val[MEM_AW-1:0]];

  // Unsigned relation; kind 0..5 = EQ, NE, LT, GT, LE, GE.
  function automatic logic rel_true(input logic [2:0] kind,
                                    input logic [DW-1:0] a,
                                    input logic [DW-1:0] b);
    case (kind)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return a < b;
      3'd3:    return a > b;
      3'd4:    return a <= b;
      3'd5:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  logic [2:0] cmp_kind, jmp_kind;
  assign cmp_kind = 3'(f_op - OP_EQ);
  assign jmp_kind = 3'(f_op - OP_JEQ);

  logic [PC_W-1:0] pc_inc;
  assign pc_inc = pc_q + 1'b1;   // wraps naturally at 2**PC_W

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    putc_valid_d = putc_valid_q;
    putc_data_d  = putc_data_q;
    getc_ready_d = getc_ready_q;
    halted_d     = halted_q;
    dst_d        = dst_q;
    rf_we        = 1'b0;
    rf_wa        = f_dst;
    rf_wd        = s_val;
    ram_we       = 1'b0;

    case (state_q)
      ST_FETCH: state_d = ST_EXEC;

      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        dst_d   = f_dst;
        case (f_op)
          OP_MOV:   rf_we = 1'b1;
          OP_ADD: begin rf_we = 1'b1; rf_wd = d_val + s_val; end
          OP_SUB: begin rf_we = 1'b1; rf_wd = d_val - s_val; end
          OP_LOAD: begin rf_we = 1'b1; rf_wd = ram_rd; end
          OP_STORE: ram_we = 1'b1;
          OP_EQ, OP_NE, OP_LT, OP_GT, OP_LE, OP_GE: begin
            rf_we = 1'b1;
            rf_wd = {{(DW-1){1'b0}}, rel_true(cmp_kind, d_val, s_val)};
          end
          OP_JEQ, OP_JNE, OP_JLT, OP_JGT, OP_JLE, OP_JGE: begin
            // Conditional jumps always compare against reg[src]; imm is the target.
            if (rel_true(jmp_kind, d_val, src_reg)) pc_d = f_imm[PC_W-1:0];
          end
          OP_JMP: pc_d = s_val[PC_W-1:0];
          OP_PUTC: begin
            state_d      = ST_PUTC;
            pc_d         = pc_q;
            putc_valid_d = 1'b1;
            putc_data_d  = d_val[7:0];
          end
          OP_GETC: begin
            state_d      = ST_GETC;
            pc_d         = pc_q;
            getc_ready_d = 1'b1;
          end
          default: begin   // EXIT and undefined opcodes
            state_d  = ST_HALT;
            pc_d     = pc_q;
            halted_d = 1'b1;
          end
        endcase
      end

      ST_PUTC: begin
        if (putc_ready) begin
          putc_valid_d = 1'b0;
          pc_d         = pc_inc;
          state_d      = ST_FETCH;
        end
      end

      ST_GETC: begin
        if (getc_valid) begin
          rf_we        = 1'b1;
          rf_wa        = dst_q;
          rf_wd        = getc_eof ? '0 : {{(DW-8){1'b0}}, getc_data};
          getc_ready_d = 1'b0;
          pc_d         = pc_inc;
          state_d      = ST_FETCH;
        end
      end

      default: ;   // ST_HALT: frozen
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      pc_q         <= '0;
      putc_valid_q <= 1'b0;
      putc_data_q  <= '0;
      getc_ready_q <= 1'b0;
      halted_q     <= 1'b0;
      dst_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      putc_valid_q <= putc_valid_d;
      putc_data_q  <= putc_data_d;
      getc_ready_q <= getc_ready_d;
      halted_q     <= halted_d;
      dst_q        <= dst_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign putc_valid = putc_valid_q;
  assign putc_data  = putc_data_q;
  assign getc_ready = getc_ready_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_elvm_core_param.sv
// Directed testbench for elvm_core_param (DW=24, PC_W=10, MEM_AW=8).
module tb_elvm_core_param;
  import elvm_pkg::*;

  localparam int DW = 24;
  localparam int PC_W = 10;
  localparam int MEM_AW = 8;
  localparam int IW = DW + 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [PC_W-1:0] imem_addr;
  logic [IW-1:0]   imem_rdata = '0;
  logic            putc_valid;
  logic [7:0]      putc_data;
  logic            putc_ready = 1'b0;
  logic            getc_ready;
  logic            getc_valid = 1'b0;
  logic [7:0]      getc_data = '0;
  logic            getc_eof = 1'b0;
  logic            halted;
  logic [PC_W-1:0] pc;

  logic [IW-1:0] rom [2**PC_W];
  int n_tests = 0;
  int n_fail = 0;
  int xfer_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= rom[imem_addr];
  always @(posedge clk) if (rst_n && putc_valid && putc_ready) xfer_cnt++;

  elvm_core_param #(.DW(DW), .PC_W(PC_W), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .putc_valid(putc_valid), .putc_data(putc_data), .putc_ready(putc_ready),
    .getc_ready(getc_ready), .getc_valid(getc_valid), .getc_data(getc_data),
    .getc_eof(getc_eof), .halted(halted), .pc(pc)
  );

  function automatic logic [IW-1:0] enc(input logic [4:0] op, input logic simm,
                                        input logic [2:0] d, input logic [2:0] s,
                                        input logic [DW-1:0] imm);
    return {op, simm, d, s, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", tag, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 2**PC_W; i++) rom[i] = enc(OP_EXIT, 1'b0, 3'd0, 3'd0, '0);
  endtask

  // Reset pulse; returns just after the edge-aligned release (first FETCH next edge).
  task automatic start();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input string tag);
    for (int n = 0; n < 200 && !halted; n++) tick();
    check(tag, 32'(halted), 32'd1);
  endtask

  initial begin
    clear_rom();
    #3 rst_n = 1'b0;
    #1;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_putc_valid", 32'(putc_valid), 32'd0);
    check("rst_getc_ready", 32'(getc_ready), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_putc_data", 32'(putc_data), 32'd0);

    // Arithmetic wrap
    clear_rom();
    rom[0] = enc(OP_MOV, 1'b1, REG_A, 3'd0, 24'hFFFFFF);
    rom[1] = enc(OP_ADD, 1'b1, REG_A, 3'd0, 24'd2);
    rom[2] = enc(OP_SUB, 1'b1, REG_A, 3'd0, 24'd2);
    start();
    repeat (4) tick();
    check("add_wrap", 32'(dut.u_rf.regs_q[0]), 32'h000001);
    wait_halt("arith_halt");
    check("sub_wrap", 32'(dut.u_rf.regs_q[0]), 32'hFFFFFF);
    check("arith_pc", 32'(pc), 32'd3);

    // STORE/LOAD with address truncation
    clear_rom();
    rom[0] = enc(OP_MOV, 1'b1, REG_B, 3'd0, 24'h41);
    rom[1] = enc(OP_STORE, 1'b1, REG_B, 3'd0, 24'h105);
    rom[2] = enc(OP_LOAD, 1'b1, REG_C, 3'd0, 24'h05);
    start();
    wait_halt("mem_halt");
    check("load_trunc", 32'(dut.u_rf.regs_q[2]), 32'h41);

    // Jumps and compares
    clear_rom();
    rom[0]     = enc(OP_MOV, 1'b1, REG_A, 3'd0, 24'd3);
    rom[1]     = enc(OP_MOV, 1'b1, REG_B, 3'd0, 24'd5);
    rom[2]     = enc(OP_JLT, 1'b0, REG_A, REG_B, 24'h20);
    rom[10'h20] = enc(OP_JGE, 1'b0, REG_A, REG_B, 24'h30);
    rom[10'h21] = enc(OP_MOV, 1'b1, REG_C, 3'd0, 24'd7);
    rom[10'h22] = enc(OP_LE, 1'b1, REG_C, 3'd0, 24'd7);
    rom[10'h23] = enc(OP_MOV, 1'b1, REG_D, 3'd0, 24'd9);
    rom[10'h24] = enc(OP_GT, 1'b0, REG_D, REG_B, 24'd0);
    start();
    repeat (6) tick();
    check("jlt_taken_pc", 32'(pc), 32'h20);
    wait_halt("jmp_halt");
    check("jge_not_taken_pc", 32'(pc), 32'h25);
    check("le_result", 32'(dut.u_rf.regs_q[2]), 32'd1);
    check("gt_reg_result", 32'(dut.u_rf.regs_q[3]), 32'd1);

    // PC wrap 0x3FF -> 0, JMP immediate, JNE against zero register
    clear_rom();
    rom[0]      = enc(OP_JNE, 1'b0, REG_SP, 3'd6, 24'h10);
    rom[1]      = enc(OP_MOV, 1'b1, REG_SP, 3'd0, 24'd1);
    rom[2]      = enc(OP_JMP, 1'b1, 3'd0, 3'd0, 24'h3FF);
    rom[10'h3FF] = enc(OP_ADD, 1'b1, REG_BP, 3'd0, 24'd1);
    start();
    wait_halt("wrap_halt");
    check("wrap_pc", 32'(pc), 32'h10);
    check("wrap_bp", 32'(dut.u_rf.regs_q[5]), 32'd1);

    // PUTC with backpressure
    clear_rom();
    rom[0] = enc(OP_MOV, 1'b1, REG_A, 3'd0, 24'h148);
    rom[1] = enc(OP_PUTC, 1'b0, REG_A, 3'd0, 24'd0);
    putc_ready = 1'b0;
    start();
    begin
      int base;
      int held;
      base = xfer_cnt;
      for (int n = 0; n < 50 && !putc_valid; n++) tick();
      check("putc_valid_seen", 32'(putc_valid), 32'd1);
      check("putc_data", 32'(putc_data), 32'h48);
      held = 0;
      for (int n = 0; n < 5; n++) begin
        tick();
        if (putc_valid && putc_data == 8'h48) held++;
      end
      check("putc_held_5", 32'(held), 32'd5);
      putc_ready = 1'b1;
      tick();
      putc_ready = 1'b0;
      check("putc_drop", 32'(putc_valid), 32'd0);
      wait_halt("putc_halt");
      check("putc_xfers", 32'(xfer_cnt - base), 32'd1);
      check("putc_pc", 32'(pc), 32'd2);
    end

    // GETC: data then EOF
    clear_rom();
    rom[0] = enc(OP_MOV, 1'b1, REG_C, 3'd0, 24'h55);
    rom[1] = enc(OP_GETC, 1'b0, REG_B, 3'd0, 24'd0);
    rom[2] = enc(OP_GETC, 1'b0, REG_C, 3'd0, 24'd0);
    start();
    for (int n = 0; n < 50 && !getc_ready; n++) tick();
    check("getc_ready_1", 32'(getc_ready), 32'd1);
    repeat (3) tick();
    check("getc_wait", 32'(getc_ready), 32'd1);
    getc_valid = 1'b1; getc_data = 8'h7A; getc_eof = 1'b0;
    tick();
    getc_valid = 1'b0;
    check("getc_data_b", 32'(dut.u_rf.regs_q[1]), 32'h7A);
    check("getc_ready_drop", 32'(getc_ready), 32'd0);
    for (int n = 0; n < 50 && !getc_ready; n++) tick();
    check("getc_ready_2", 32'(getc_ready), 32'd1);
    getc_valid = 1'b1; getc_data = 8'h33; getc_eof = 1'b1;
    tick();
    getc_valid = 1'b0; getc_eof = 1'b0;
    check("getc_eof_c", 32'(dut.u_rf.regs_q[2]), 32'd0);
    wait_halt("getc_halt");
    check("getc_pc", 32'(pc), 32'd3);

    // Reset mid-PUTC
    clear_rom();
    rom[0] = enc(OP_MOV, 1'b1, REG_A, 3'd0, 24'h148);
    rom[1] = enc(OP_PUTC, 1'b0, REG_A, 3'd0, 24'd0);
    putc_ready = 1'b0;
    start();
    for (int n = 0; n < 50 && !putc_valid; n++) tick();
    check("mid_putc_valid", 32'(putc_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_putc_valid", 32'(putc_valid), 32'd0);
    check("mid_rst_pc", 32'(pc), 32'd0);
    check("mid_rst_putc_data", 32'(putc_data), 32'd0);

    // EXIT at address 0: frozen
    clear_rom();
    start();
    wait_halt("exit_halt");
    repeat (10) tick();
    check("exit_pc_frozen", 32'(pc), 32'd0);
    check("exit_still_halted", 32'(halted), 32'd1);

    // Undefined opcode halts
    clear_rom();
    rom[0] = enc(OP_MOV, 1'b1, REG_A, 3'd0, 24'd1);
    rom[1] = enc(5'd31, 1'b1, REG_A, 3'd0, 24'd0);
    rom[2] = enc(OP_MOV, 1'b1, REG_A, 3'd0, 24'd2);
    start();
    wait_halt("illegal_halt");
    check("illegal_pc", 32'(pc), 32'd1);
    check("illegal_a", 32'(dut.u_rf.regs_q[0]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
